// File: rtl/puf_response_capture_if.sv
// Signal bundle between the RO comparator/counter side and the PUF response-capture stage.
// The master drives raw response bits, the evaluation count and re-arm; the slave returns the voted result.
interface puf_response_capture_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
);
   logic [WIDTH-1:0] In;
   logic [CNT_W-1:0] count;
   logic             start;
   logic [WIDTH-1:0] Out;
   logic [WIDTH-1:0] stable_mask;
   logic             valid;
   logic [3:0]       sample_cnt;

   modport master (
      output In, count, start,
      input  Out, stable_mask, valid, sample_cnt
   );

   modport slave (
      input  In, count, start,
      output Out, stable_mask, valid, sample_cnt
   );
endinterface

// File: rtl/puf_response_capture.sv
// Samples the PUF response on each entry of the evaluation counter into CAPTURE_AT.
// After SAMPLES captures it resolves a bitwise majority vote and a unanimity mask.
module puf_response_capture #(
   parameter int WIDTH      = 16,
   parameter int CNT_W      = 5,
   parameter int CAPTURE_AT = 20,
   parameter int SAMPLES    = 5
) (
   input  logic                   clk,
   input  logic                   Reset,
   puf_response_capture_if.slave  bus
);
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      RESOLVE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_count_q;
   logic [3:0]       r_sample_cnt;
   logic [3:0]       r_ones [WIDTH];
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_mask;
   logic             r_valid;

   logic             w_match;
   logic             w_accept;
   logic             w_clear;
   logic [WIDTH-1:0] w_vote;
   logic [WIDTH-1:0] w_unan;

   // Edge-detect on the counter so a stalled or saturated count yields one sample.
   assign w_match  = (bus.count == CNT_W'(CAPTURE_AT)) && (r_count_q != CNT_W'(CAPTURE_AT));
   assign w_clear  = Reset || bus.start;
   assign w_accept = (r_state == COLLECT) && w_match && !bus.start;

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (bus.start) begin
         w_state_next = COLLECT;
      end else begin
         case (r_state)
            COLLECT: begin
               if (w_match && (r_sample_cnt + 4'd1 == 4'(SAMPLES))) begin
                  w_state_next = RESOLVE;
               end
            end
            RESOLVE: w_state_next = DONE;
            DONE:    w_state_next = DONE;
            default: w_state_next = COLLECT;
         endcase
      end
   end

   // count_q survives start so a count parked at CAPTURE_AT is not re-captured.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_count_q <= '0;
      end else begin
         r_count_q <= bus.count;
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_sample_cnt <= 4'd0;
      end else if (w_accept) begin
         r_sample_cnt <= r_sample_cnt + 4'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk) begin
            if (w_clear) begin
               r_ones[gi] <= 4'd0;
            end else if (w_accept) begin
               r_ones[gi] <= r_ones[gi] + {3'd0, bus.In[gi]};
            end
         end

         assign w_vote[gi] = (r_ones[gi] > 4'(SAMPLES / 2));
         assign w_unan[gi] = (r_ones[gi] == 4'd0) || (r_ones[gi] == 4'(SAMPLES));
      end
   endgenerate

   // Result registers stay zero until the one-cycle resolve, then hold until cleared.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_out   <= '0;
         r_mask  <= '0;
         r_valid <= 1'b0;
      end else if (r_state == RESOLVE) begin
         r_out   <= w_vote;
         r_mask  <= w_unan;
         r_valid <= 1'b1;
      end
   end

   assign bus.Out         = r_out;
   assign bus.stable_mask = r_mask;
   assign bus.valid       = r_valid;
   assign bus.sample_cnt  = r_sample_cnt;
endmodule

// File: doc/puf_response_capture.md
# puf_response_capture

Parametrised response-capture stage for the ring-oscillator PUF key path. It samples the WIDTH-bit PUF comparator response each time the evaluation counter reaches CAPTURE_AT, over SAMPLES independent evaluations. It then resolves a bitwise majority-voted response and a per-bit stability mask, and holds both with a valid flag until re-armed. It sits between the RO comparator/counter logic and the key-generation/AES key register.

## Interface

- WIDTH, 16, response width in bits
- CNT_W, 5, width of the evaluation counter input
- CAPTURE_AT, 20, counter value at which In is sampled; must be 1..2^CNT_W-1
- SAMPLES, 5, evaluations voted per response; odd, 1..15

- clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- In  in  WIDTH  raw PUF response bits
- count  in  CNT_W  evaluation counter from the RO counter block
- start  in  1  single-cycle re-arm pulse
- Out  out  WIDTH  majority-voted response; 0 until valid
- stable_mask  out  WIDTH  1 = bit was unanimous across all samples; 0 until valid
- valid  out  1  Out/stable_mask hold a resolved result
- sample_cnt  out  4  evaluations accumulated in the current run

## Operation

- States: COLLECT, RESOLVE, DONE. Reset enters COLLECT with the block already armed; no start is needed after reset.
- Reset values: Out=0, stable_mask=0, valid=0, sample_cnt=0, all per-bit ones-counters=0, count_q=0, state=COLLECT.
- Match event: count==CAPTURE_AT && count_q!=CAPTURE_AT. count_q is count registered every cycle.
  - Triggers only on entry to CAPTURE_AT. A counter that stalls or saturates at CAPTURE_AT yields exactly one sample.
- COLLECT, on a match event:
  - For each bit i, ones[i] += In[i]. Ones-counters are 4 bits wide and never exceed SAMPLES.
  - sample_cnt += 1.
  - If the new sample_cnt == SAMPLES, go to RESOLVE.
- RESOLVE (one cycle):
  - Out[i] = (ones[i] > SAMPLES/2), using integer division.
  - stable_mask[i] = (ones[i]==0) || (ones[i]==SAMPLES).
  - valid <= 1; go to DONE.
- DONE: Out, stable_mask and valid hold. Match events are ignored.
- start, in any state: clear ones-counters, sample_cnt, Out, stable_mask and valid to 0, and go to COLLECT.
  - start has priority over a coincident match event; that sample is discarded.
  - start has priority over RESOLVE; no result is produced.
- Out is held at 0 outside valid, so downstream never sees a partial response.

## Timing

- The match is detected combinationally from count and count_q. Accumulation happens on the same rising edge on which count==CAPTURE_AT is first present.
- Final sample accepted at edge k: state=RESOLVE after edge k; Out, stable_mask and valid update at edge k+1. Latency from the final match cycle to valid is 2 edges.
- start sampled at edge j: all outputs are 0 after edge j. The next match may be counted from edge j+1.
- Reset sampled at edge r: all outputs are 0 after edge r, regardless of state. An in-progress run is discarded.
- After a start or Reset, count_q is cleared to 0 (Reset) or retained (start). If start occurs while count==CAPTURE_AT, that value is not re-captured until count leaves and re-enters CAPTURE_AT.
- SAMPLES=1 degenerates to single-shot capture: Out=In at the match, with stable_mask all ones.

## Test plan

- Five evaluations (count sweeps 0→20→0), In=16'hA5C3 at every match -> valid rises 2 edges after the 5th match; Out=16'hA5C3, stable_mask=16'hFFFF, sample_cnt=5.
- Five evaluations with In = 0001, 0001, 0001, 0000, 0000 (hex) -> Out=16'h0001; stable_mask=16'hFFFE (bit0 unstable, others unanimous 0).
- count saturates at 20 for 30 cycles, then restarts, repeated 5 times -> exactly 5 samples counted, not 150; valid asserts once.
- start pulsed after 3 samples, coincident with the 4th match -> sample_cnt=0 and valid=0 next cycle; 5 further matches are needed for valid; Out reflects only the post-start samples.
- Reset asserted in RESOLVE, and again in DONE with Out=16'hFFFF -> next cycle Out=0, valid=0, stable_mask=0, sample_cnt=0; a fresh 5-sample run then completes normally.
- Matches arriving while in DONE with different In -> Out and stable_mask unchanged until start.
